phys_free_list: RTL and testbench

//   Circular free list of physical registers feeding the rename stage. Presents the next free

---
 rtl/phys_free_list.sv | 116 +++++++++++
 tb/tb_phys_free_list.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/phys_free_list.sv
// Circular free list of physical register tags for rename. A speculative head serves rename and
// a committed head tracks retired grabs, so a flush can give back every squashed grab in one cycle.
module phys_free_list #(
    parameter int NUM_PHYS = 64,
    parameter int LOG_PHYS = 6,
    parameter int NUM_ARCH = 32
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                Grabbed_regs,
    input  logic                Retire_grab,
    input  logic                Free_valid_IN,
    input  logic [LOG_PHYS-1:0] Free_phys_IN,
    input  logic                Flush,
    output logic [LOG_PHYS-1:0] Free_phys_reg,
    output logic                Free_reg_avail,
    output logic [LOG_PHYS:0]   Free_count,
    output logic                List_error
);

    localparam logic [LOG_PHYS-1:0] PTR_ONE  = LOG_PHYS'(1);
    localparam logic [LOG_PHYS-1:0] PTR_INIT = LOG_PHYS'(NUM_PHYS - NUM_ARCH);
    localparam logic [LOG_PHYS:0]   CNT_ONE  = (LOG_PHYS + 1)'(1);
    localparam logic [LOG_PHYS:0]   CNT_INIT = (LOG_PHYS + 1)'(NUM_PHYS - NUM_ARCH);
    localparam logic [LOG_PHYS:0]   CNT_FULL = (LOG_PHYS + 1)'(NUM_PHYS);

    logic [LOG_PHYS-1:0] r_mem [NUM_PHYS];
    logic [LOG_PHYS-1:0] r_spec_head;
    logic [LOG_PHYS-1:0] r_commit_head;
    logic [LOG_PHYS-1:0] r_tail;
    logic [LOG_PHYS:0]   r_spec_cnt;
    logic [LOG_PHYS:0]   r_commit_cnt;
    logic                r_list_error;

    logic                w_pop_req;
    logic                w_pop;
    logic                w_underflow;
    logic                w_push_req;
    logic                w_push;
    logic                w_overflow;
    logic                w_commit;
    logic                w_overrun;
    logic [LOG_PHYS-1:0] w_commit_head_n;
    logic [LOG_PHYS:0]   w_commit_cnt_n;
    logic [LOG_PHYS-1:0] w_spec_head_n;
    logic [LOG_PHYS:0]   w_spec_cnt_n;
    logic [LOG_PHYS-1:0] w_tail_n;

    // Handshake: Free_reg_avail is the valid for Free_phys_reg; Grabbed_regs is the consumer's
    // take strobe and only pops when avail was high, otherwise it is an underflow error.
    always_comb begin
        w_pop_req       = Grabbed_regs && !Flush;
        w_pop           = w_pop_req && (r_spec_cnt != '0);
        w_underflow     = w_pop_req && (r_spec_cnt == '0);

        w_push_req      = Free_valid_IN && (Free_phys_IN != '0);
        w_push          = w_push_req && (r_commit_cnt != CNT_FULL);
        w_overflow      = w_push_req && (r_commit_cnt == CNT_FULL);

        w_commit        = Retire_grab && (r_commit_head != r_spec_head);
        w_overrun       = Retire_grab && (r_commit_head == r_spec_head);

        w_commit_head_n = w_commit ? (r_commit_head + PTR_ONE) : r_commit_head;
        w_commit_cnt_n  = r_commit_cnt + (w_push ? CNT_ONE : '0) - (w_commit ? CNT_ONE : '0);
        w_tail_n        = w_push ? (r_tail + PTR_ONE) : r_tail;

        // A flush rewinds onto the committed view as it stands after this cycle's commit and push.
        if (Flush) begin
            w_spec_head_n = w_commit_head_n;
            w_spec_cnt_n  = w_commit_cnt_n;
        end else begin
            w_spec_head_n = w_pop ? (r_spec_head + PTR_ONE) : r_spec_head;
            w_spec_cnt_n  = r_spec_cnt + (w_push ? CNT_ONE : '0) - (w_pop ? CNT_ONE : '0);
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < NUM_PHYS; i++) begin
                r_mem[i] <= (i < NUM_PHYS - NUM_ARCH) ? LOG_PHYS'(NUM_ARCH + i) : '0;
            end
            r_spec_head   <= '0;
            r_commit_head <= '0;
            r_tail        <= PTR_INIT;
            r_spec_cnt    <= CNT_INIT;
            r_commit_cnt  <= CNT_INIT;
            r_list_error  <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_tail] <= Free_phys_IN;
            end
            r_spec_head   <= w_spec_head_n;
            r_commit_head <= w_commit_head_n;
            r_tail        <= w_tail_n;
            r_spec_cnt    <= w_spec_cnt_n;
            r_commit_cnt  <= w_commit_cnt_n;
            if (w_underflow || w_overflow || w_overrun) begin
                r_list_error <= 1'b1;
            end
        end
    end

    assign Free_phys_reg  = r_mem[r_spec_head];
    assign Free_reg_avail = (r_spec_cnt != '0);
    assign Free_count     = r_spec_cnt;
    assign List_error     = r_list_error;

    always @(posedge CLK) begin
        if (RESET) begin
            assert (r_spec_cnt <= r_commit_cnt);
            assert (r_commit_cnt <= CNT_FULL);
            assert ((r_tail - r_spec_head) == r_spec_cnt[LOG_PHYS-1:0]);
        end
    end

endmodule

// File: tb/tb_phys_free_list.sv
// Directed bench for phys_free_list: reset values, drain/underflow, refill, flush rewind,
// wrap-around streaming, overflow, commit overrun and asynchronous reset.
module tb_phys_free_list;

    logic       CLK;
    logic       RESET;
    logic       Grabbed_regs;
    logic       Retire_grab;
    logic       Free_valid_IN;
    logic [5:0] Free_phys_IN;
    logic       Flush;
    logic [5:0] Free_phys_reg;
    logic       Free_reg_avail;
    logic [6:0] Free_count;
    logic       List_error;

    int n_checks = 0;
    int n_fail   = 0;
    logic [5:0] exp_q[$];

    phys_free_list #(.NUM_PHYS(64), .LOG_PHYS(6), .NUM_ARCH(32)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .Grabbed_regs   (Grabbed_regs),
        .Retire_grab    (Retire_grab),
        .Free_valid_IN  (Free_valid_IN),
        .Free_phys_IN   (Free_phys_IN),
        .Flush          (Flush),
        .Free_phys_reg  (Free_phys_reg),
        .Free_reg_avail (Free_reg_avail),
        .Free_count     (Free_count),
        .List_error     (List_error)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic grab, input logic retire, input logic fv,
                         input logic [5:0] fp, input logic flush);
        Grabbed_regs  = grab;
        Retire_grab   = retire;
        Free_valid_IN = fv;
        Free_phys_IN  = fp;
        Flush         = flush;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
        RESET = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b1;
    endtask

    initial begin
        RESET = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
        #2;
        RESET = 1'b0;
        #1;
        check_val("in_reset_reg", int'(Free_phys_reg), 32);
        check_val("in_reset_count", int'(Free_count), 32);
        @(posedge CLK);
        #1;
        RESET = 1'b1;

        // Idle after reset
        repeat (3) tick();
        check_val("idle_reg", int'(Free_phys_reg), 32);
        check_val("idle_avail", int'(Free_reg_avail), 1);
        check_val("idle_count", int'(Free_count), 32);
        check_val("idle_err", int'(List_error), 0);

        // Drain all 32 free tags, then underflow
        for (int k = 0; k < 32; k++) begin
            check_val("drain_tag", int'(Free_phys_reg), 32 + k);
            drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
            tick();
        end
        check_val("drain_avail", int'(Free_reg_avail), 0);
        check_val("drain_count", int'(Free_count), 0);
        check_val("drain_err", int'(List_error), 0);
        drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
        tick();
        check_val("underflow_err", int'(List_error), 1);
        check_val("underflow_count", int'(Free_count), 0);

        // From empty: push 5 together with a grab (grab underflows, push lands)
        drive(1'b1, 1'b0, 1'b1, 6'd5, 1'b0);
        tick();
        check_val("refill_reg", int'(Free_phys_reg), 5);
        check_val("refill_count", int'(Free_count), 1);
        tick();
        check_val("refill_hold_reg", int'(Free_phys_reg), 5);
        check_val("refill_hold_count", int'(Free_count), 1);
        drive(1'b1, 1'b0, 1'b1, 6'd7, 1'b0);
        tick();
        check_val("poppush_reg", int'(Free_phys_reg), 7);
        check_val("poppush_count", int'(Free_count), 1);

        // Grab 4, retire 1, flush -> rewind to the second tag
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
            tick();
        end
        check_val("grab4_reg", int'(Free_phys_reg), 36);
        drive(1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
        tick();
        check_val("retire_count", int'(Free_count), 28);
        drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b1);
        tick();
        check_val("flush_reg", int'(Free_phys_reg), 33);
        check_val("flush_count", int'(Free_count), 31);
        drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b1);
        tick();
        check_val("reflush_grab_ignored_reg", int'(Free_phys_reg), 33);
        check_val("reflush_count", int'(Free_count), 31);
        check_val("flush_err", int'(List_error), 0);

        // Streaming grab/free for 100 cycles: pointers wrap, order follows the expected queue
        do_reset();
        exp_q.delete();
        for (int k = 0; k < 32; k++) exp_q.push_back(6'(32 + k));
        for (int k = 0; k < 100; k++) begin
            logic [5:0] fp;
            logic [5:0] exp_tag;
            fp = 6'(32 + (k % 32));
            exp_tag = exp_q.pop_front();
            check_val("stream_tag", int'(Free_phys_reg), int'(exp_tag));
            exp_q.push_back(fp);
            drive(1'b1, (k > 0), 1'b1, fp, 1'b0);
            tick();
            check_val("stream_count", int'(Free_count), 32);
        end
        drive(1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
        tick();
        check_val("stream_err", int'(List_error), 0);
        check_val("stream_head", int'(Free_phys_reg), int'(exp_q[0]));
        drive(1'b0, 1'b0, 1'b1, 6'd0, 1'b0);
        tick();
        check_val("phys0_count", int'(Free_count), 32);
        drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b1);
        tick();
        check_val("stream_flush_count", int'(Free_count), 32);
        check_val("stream_flush_err", int'(List_error), 0);

        // Overflow: committed count reaches 64, next push is dropped
        do_reset();
        for (int k = 0; k < 32; k++) begin
            drive(1'b0, 1'b0, 1'b1, 6'(1 + k), 1'b0);
            tick();
        end
        check_val("full_count", int'(Free_count), 64);
        check_val("full_err", int'(List_error), 0);
        drive(1'b0, 1'b0, 1'b1, 6'd9, 1'b0);
        tick();
        check_val("overflow_err", int'(List_error), 1);
        check_val("overflow_count", int'(Free_count), 64);

        // Commit overrun: retire with nothing grabbed
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
        tick();
        check_val("overrun_err", int'(List_error), 1);
        check_val("overrun_count", int'(Free_count), 32);

        // Asynchronous reset mid-burst, between clock edges
        drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
        @(posedge CLK);
        @(posedge CLK);
        #3;
        RESET = 1'b0;
        #1;
        check_val("async_reg", int'(Free_phys_reg), 32);
        check_val("async_avail", int'(Free_reg_avail), 1);
        check_val("async_count", int'(Free_count), 32);
        check_val("async_err", int'(List_error), 0);
        drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        tick();
        check_val("post_async_reg", int'(Free_phys_reg), 32);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
